// File: rtl/mem_queue_mc_if.sv
// rtl/mem_queue_mc_if.sv - request/response/search bundle between requesters, DRAM side and mem_queue_mc
interface mem_queue_mc_if #(
  parameter int NUM_CH         = 4,
  parameter int CH_BIT         = 2,
  parameter int REQUEST_SIZE   = 38,
  parameter int ADDR_WIDTH     = 32,
  parameter int QUEUE_SIZE_BIT = 4
);
  logic [NUM_CH-1:0]              push_en;
  logic [2*NUM_CH-1:0]            op;
  logic [NUM_CH*REQUEST_SIZE-1:0] buf_in;
  logic                           out_ready;
  logic                           search_en;
  logic [ADDR_WIDTH-1:0]          search_addr;

  logic                           out_valid;
  logic [REQUEST_SIZE-1:0]        buf_out;
  logic [1:0]                     op_out;
  logic [CH_BIT-1:0]              out_ch;
  logic                           search_match;
  logic [CH_BIT-1:0]              search_match_ch;
  logic [QUEUE_SIZE_BIT-1:0]      search_match_index;
  logic [NUM_CH-1:0]              empty;
  logic [NUM_CH-1:0]              full;
  logic [NUM_CH-1:0]              overflow;

  modport master (
    output push_en, op, buf_in, out_ready, search_en, search_addr,
    input  out_valid, buf_out, op_out, out_ch, search_match, search_match_ch,
           search_match_index, empty, full, overflow
  );

  modport slave (
    input  push_en, op, buf_in, out_ready, search_en, search_addr,
    output out_valid, buf_out, op_out, out_ch, search_match, search_match_ch,
           search_match_index, empty, full, overflow
  );
endinterface

// File: rtl/mem_queue_mc.sv
// rtl/mem_queue_mc.sv - per-channel request FIFOs, round-robin drain to DRAM, pending-write address search
module mem_queue_mc #(
  parameter int NUM_CH         = 4,
  parameter int CH_BIT         = 2,
  parameter int REQUEST_SIZE   = 38,
  parameter int ADDR_WIDTH     = 32,
  parameter int QUEUE_SIZE     = 16,
  parameter int QUEUE_SIZE_BIT = 4
) (
  input logic          clk,
  input logic          rst,
  mem_queue_mc_if.slave bus
);
  localparam int CNT_W = QUEUE_SIZE_BIT + 1;

  logic [REQUEST_SIZE-1:0]   mem        [NUM_CH][QUEUE_SIZE];
  logic [1:0]                op_mem     [NUM_CH][QUEUE_SIZE];
  logic [QUEUE_SIZE-1:0]     slot_valid [NUM_CH];
  logic [QUEUE_SIZE_BIT-1:0] wr_ptr     [NUM_CH];
  logic [QUEUE_SIZE_BIT-1:0] rd_ptr     [NUM_CH];
  logic [CNT_W-1:0]          count      [NUM_CH];
  logic [CNT_W-1:0]          count_nxt  [NUM_CH];

  logic [NUM_CH-1:0]         empty_r, full_r, overflow_r;
  logic [NUM_CH-1:0]         push_ok, pop;
  logic [CH_BIT-1:0]         rr_ptr, grant;
  logic                      out_valid, handshake;

  logic                      hit;
  logic [CH_BIT-1:0]         hit_ch;
  logic [QUEUE_SIZE_BIT-1:0] hit_idx;
  logic                      match_r;
  logic [CH_BIT-1:0]         match_ch_r;
  logic [QUEUE_SIZE_BIT-1:0] match_idx_r;

  assign out_valid = ~&empty_r;
  assign handshake = out_valid & bus.out_ready;

  // Scan from the far end so the first non-empty channel after rr_ptr wins.
  always_comb begin
    grant = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (!empty_r[rr_ptr + CH_BIT'(k)]) grant = rr_ptr + CH_BIT'(k);
    end
  end

  always_comb begin
    pop     = '0;
    push_ok = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pop[c]       = handshake && (grant == CH_BIT'(c));
      push_ok[c]   = bus.push_en[c] && (!full_r[c] || pop[c]);
      count_nxt[c] = count[c] + CNT_W'(push_ok[c]) - CNT_W'(pop[c]);
    end
  end

  // Lowest channel, then lowest slot, wins: later (lower) hits overwrite earlier ones.
  always_comb begin
    hit     = 1'b0;
    hit_ch  = '0;
    hit_idx = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      for (int i = QUEUE_SIZE - 1; i >= 0; i--) begin
        if (slot_valid[c][i] && op_mem[c][i] == 2'b01 &&
            mem[c][i][ADDR_WIDTH-1:0] == bus.search_addr) begin
          hit     = 1'b1;
          hit_ch  = CH_BIT'(c);
          hit_idx = QUEUE_SIZE_BIT'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push_ok[c]) begin
        mem[c][wr_ptr[c]]    <= bus.buf_in[c*REQUEST_SIZE +: REQUEST_SIZE];
        op_mem[c][wr_ptr[c]] <= bus.op[2*c +: 2];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c]     <= '0;
        rd_ptr[c]     <= '0;
        count[c]      <= '0;
        slot_valid[c] <= '0;
      end
      empty_r     <= '1;
      full_r      <= '0;
      overflow_r  <= '0;
      rr_ptr      <= '0;
      match_r     <= 1'b0;
      match_ch_r  <= '0;
      match_idx_r <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        // Clear before set: a push into the slot being popped (full channel) keeps it valid.
        if (pop[c]) begin
          slot_valid[c][rd_ptr[c]] <= 1'b0;
          rd_ptr[c]                <= rd_ptr[c] + QUEUE_SIZE_BIT'(1);
        end
        if (push_ok[c]) begin
          slot_valid[c][wr_ptr[c]] <= 1'b1;
          wr_ptr[c]                <= wr_ptr[c] + QUEUE_SIZE_BIT'(1);
        end
        count[c]      <= count_nxt[c];
        empty_r[c]    <= (count_nxt[c] == '0);
        full_r[c]     <= (count_nxt[c] == CNT_W'(QUEUE_SIZE));
        overflow_r[c] <= bus.push_en[c] && full_r[c] && !pop[c];
      end
      if (handshake) rr_ptr <= grant + CH_BIT'(1);
      match_r <= bus.search_en && hit;
      if (bus.search_en && hit) begin
        match_ch_r  <= hit_ch;
        match_idx_r <= hit_idx;
      end
    end
  end

  assign bus.out_valid          = out_valid;
  assign bus.buf_out            = out_valid ? mem[grant][rd_ptr[grant]] : '0;
  assign bus.op_out             = out_valid ? op_mem[grant][rd_ptr[grant]] : 2'b00;
  assign bus.out_ch             = grant;
  assign bus.search_match       = match_r;
  assign bus.search_match_ch    = match_ch_r;
  assign bus.search_match_index = match_idx_r;
  assign bus.empty              = empty_r;
  assign bus.full               = full_r;
  assign bus.overflow           = overflow_r;
endmodule
